// File: rtl/alu_exec.sv
// ============================================================================
// Module   : alu_exec
// Purpose  : MIPS-style execute stage with valid/ready handshake, branch
//            evaluation and an iterative (or, with ALU_EXEC_FAST_MUL_EN,
//            single-cycle) 32-bit multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [5:0]  i_alu_control,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    input  logic        i_rt_sel,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_branch_taken,
    output logic        o_bad_op
);

    localparam logic [5:0] C_OP_ADD  = 6'b100000;
    localparam logic [5:0] C_OP_SUB  = 6'b100010;
    localparam logic [5:0] C_OP_AND  = 6'b100100;
    localparam logic [5:0] C_OP_OR   = 6'b100101;
    localparam logic [5:0] C_OP_NOR  = 6'b100111;
    localparam logic [5:0] C_OP_XOR  = 6'b100110;
    localparam logic [5:0] C_OP_SLT  = 6'b101010;
    localparam logic [5:0] C_OP_SLL  = 6'b000000;
    localparam logic [5:0] C_OP_SRL  = 6'b000010;
    localparam logic [5:0] C_OP_JR   = 6'b001000;
    localparam logic [5:0] C_OP_JAL  = 6'b000011;
    localparam logic [5:0] C_OP_MUL  = 6'b011000;
    localparam logic [5:0] C_OP_BEQ  = 6'b000100;
    localparam logic [5:0] C_OP_BNE  = 6'b000101;
    localparam logic [5:0] C_OP_BGTZ = 6'b000111;
    localparam logic [5:0] C_OP_BLEZ = 6'b000110;
    localparam logic [5:0] C_OP_BREG = 6'b000001;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_BUSY = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic        r_out_valid;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_branch;
    logic        r_bad_op;

    logic [31:0] w_diff;
    logic [31:0] w_result;
    logic        w_branch;
    logic        w_bad;
    logic        w_mul_iter;
    logic        w_accept;
    logic [31:0] w_acc_next;

    assign w_diff     = i_a - i_b;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 32'd0);

    always_comb begin
        w_result   = 32'd0;
        w_branch   = 1'b0;
        w_bad      = 1'b0;
        w_mul_iter = 1'b0;
        case (i_alu_control)
            C_OP_ADD:  w_result = i_a + i_b;
            C_OP_SUB:  w_result = w_diff;
            C_OP_AND:  w_result = i_a & i_b;
            C_OP_OR:   w_result = i_a | i_b;
            C_OP_NOR:  w_result = ~(i_a | i_b);
            C_OP_XOR:  w_result = i_a ^ i_b;
            C_OP_SLT:  w_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            C_OP_SLL:  w_result = i_b << i_shamt;
            C_OP_SRL:  w_result = i_b >> i_shamt;
            C_OP_JR:   w_result = i_a;
            C_OP_JAL:  w_result = i_a;
            C_OP_MUL: begin
`ifdef ALU_EXEC_FAST_MUL_EN
                w_result = i_a * i_b;
`else
                w_mul_iter = 1'b1;
`endif
            end
            C_OP_BEQ: begin
                w_result = w_diff;
                w_branch = (i_a == i_b);
            end
            C_OP_BNE: begin
                w_result = w_diff;
                w_branch = (i_a != i_b);
            end
            C_OP_BGTZ: begin
                w_result = w_diff;
                w_branch = ~i_a[31] & (|i_a);
            end
            C_OP_BLEZ: begin
                w_result = w_diff;
                w_branch = i_a[31] | ~(|i_a);
            end
            C_OP_BREG: begin
                w_result = w_diff;
                w_branch = i_rt_sel ? ~i_a[31] : i_a[31];
            end
            default:   w_bad = 1'b1;
        endcase
    end

    // A holding DONE slot frees up in the same cycle the consumer takes it.
    always_comb begin
        o_in_ready = 1'b0;
        case (r_state)
            S_IDLE:  o_in_ready = 1'b1;
            S_DONE:  o_in_ready = i_out_ready;
            default: o_in_ready = 1'b0;
        endcase
    end

    assign w_accept = i_in_valid & o_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_mcand     <= 32'd0;
            r_mplier    <= 32'd0;
            r_acc       <= 32'd0;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_zero      <= 1'b0;
            r_branch    <= 1'b0;
            r_bad_op    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_mul_iter) begin
                            r_state     <= S_MUL_BUSY;
                            r_cnt       <= 5'd0;
                            r_mcand     <= i_a;
                            r_mplier    <= i_b;
                            r_acc       <= 32'd0;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_result;
                            r_zero      <= (w_result == 32'd0);
                            r_branch    <= w_branch;
                            r_bad_op    <= w_bad;
                        end
                    end else if ((r_state == S_DONE) && i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_MUL_BUSY: begin
                    // One multiplier bit per cycle; the 32nd step writes the result.
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_acc_next;
                        r_zero      <= (w_acc_next == 32'd0);
                        r_branch    <= 1'b0;
                        r_bad_op    <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_out_valid    = r_out_valid;
    assign o_result       = r_result;
    assign o_zero         = r_zero;
    assign o_branch_taken = r_branch;
    assign o_bad_op       = r_bad_op;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module   : tb_alu_exec
// Purpose  : Directed self-checking bench for alu_exec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        rt_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;
    logic        bad_op;

    int tests_run;
    int tests_failed;

    alu_exec u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_alu_control  (alu_control),
        .i_a            (a),
        .i_b            (b),
        .i_shamt        (shamt),
        .i_rt_sel       (rt_sel),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_result       (result),
        .o_zero         (zero),
        .o_branch_taken (branch_taken),
        .o_bad_op       (bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] ctl, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, input logic rs);
        alu_control = ctl;
        a           = av;
        b           = bv;
        shamt       = sh;
        rt_sel      = rs;
        in_valid    = 1'b1;
        step();
        in_valid    = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res, input logic z,
                           input logic br, input logic bad);
        chk({tag, "_valid"},  {31'd0, out_valid},    32'd1);
        chk({tag, "_result"}, result,                res);
        chk({tag, "_zero"},   {31'd0, zero},         {31'd0, z});
        chk({tag, "_branch"}, {31'd0, branch_taken}, {31'd0, br});
        chk({tag, "_badop"},  {31'd0, bad_op},       {31'd0, bad});
    endtask

    initial begin
        logic saw_valid;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        alu_control  = 6'd0;
        a            = 32'd0;
        b            = 32'd0;
        shamt        = 5'd0;
        rt_sel       = 1'b0;

        #2;
        chk("rst_valid",  {31'd0, out_valid},    32'd0);
        chk("rst_result", result,                32'd0);
        chk("rst_zero",   {31'd0, zero},         32'd0);
        chk("rst_branch", {31'd0, branch_taken}, 32'd0);
        chk("rst_badop",  {31'd0, bad_op},       32'd0);
        #10;
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        issue(6'b100000, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        chk_out("add_wrap", 32'd0, 1'b1, 1'b0, 1'b0);

        issue(6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        chk_out("slt", 32'd1, 1'b0, 1'b0, 1'b0);

        issue(6'b000010, 32'd0, 32'h8000_0000, 5'd31, 1'b0);
        chk_out("srl", 32'd1, 1'b0, 1'b0, 1'b0);

        issue(6'b000000, 32'd0, 32'h0000_0003, 5'd4, 1'b0);
        chk_out("sll", 32'h30, 1'b0, 1'b0, 1'b0);

        issue(6'b100111, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 1'b0);
        chk_out("nor", 32'hF0F0_FF0F, 1'b0, 1'b0, 1'b0);

        issue(6'b100110, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 1'b0);
        chk_out("xor", 32'h5555_5555, 1'b0, 1'b0, 1'b0);

        issue(6'b000011, 32'h0000_0400, 32'h1234_5678, 5'd0, 1'b0);
        chk_out("jal", 32'h0000_0400, 1'b0, 1'b0, 1'b0);

        issue(6'b111111, 32'h1234_5678, 32'h1, 5'd0, 1'b0);
        chk_out("badop", 32'd0, 1'b1, 1'b0, 1'b1);

        issue(6'b000001, 32'h8000_0000, 32'd0, 5'd0, 1'b0);
        chk_out("bltz", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        issue(6'b000001, 32'h8000_0000, 32'd0, 5'd0, 1'b1);
        chk_out("bgez", 32'h8000_0000, 1'b0, 1'b0, 1'b0);

        issue(6'b000100, 32'd5, 32'd5, 5'd0, 1'b0);
        chk_out("beq", 32'd0, 1'b1, 1'b1, 1'b0);

        issue(6'b000101, 32'd5, 32'd3, 5'd0, 1'b0);
        chk_out("bne", 32'd2, 1'b0, 1'b1, 1'b0);

        issue(6'b000111, 32'd0, 32'd0, 5'd0, 1'b0);
        chk_out("bgtz", 32'd0, 1'b1, 1'b0, 1'b0);

        issue(6'b000110, 32'd0, 32'd0, 5'd0, 1'b0);
        chk_out("blez", 32'd0, 1'b1, 1'b1, 1'b0);

        step();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_ready", {31'd0, in_ready},  32'd1);

        // Multiply (-2) * 7; operands changed while busy must not matter.
        issue(6'b011000, 32'hFFFF_FFFE, 32'd7, 5'd0, 1'b0);
        a = 32'd0;
        b = 32'd0;
`ifdef ALU_EXEC_FAST_MUL_EN
        chk_out("mul_fast", 32'hFFFF_FFF2, 1'b0, 1'b0, 1'b0);
`else
        chk("mul_busy_ready_0", {31'd0, in_ready},  32'd0);
        chk("mul_busy_valid_0", {31'd0, out_valid}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            step();
            chk("mul_busy_ready", {31'd0, in_ready},  32'd0);
            chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
        end
        step();
        chk_out("mul_iter", 32'hFFFF_FFF2, 1'b0, 1'b0, 1'b0);
`endif
        step();

        // Hold with consumer stalled, then back-to-back SUB.
        issue(6'b100000, 32'd2, 32'd3, 5'd0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk_out("hold_add", 32'd5, 1'b0, 1'b0, 1'b0);
        chk("hold_ready0", {31'd0, in_ready}, 32'd0);
        alu_control = 6'b100010;
        a           = 32'd100;
        b           = 32'd1;
        in_valid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_result", result,                5);
            chk("hold_valid",  {31'd0, out_valid},    32'd1);
            chk("hold_ready",  {31'd0, in_ready},     32'd0);
        end
        out_ready = 1'b1;
        a         = 32'd10;
        b         = 32'd3;
        #1;
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk_out("b2b_sub", 32'd7, 1'b0, 1'b0, 1'b0);
        step();
        chk("b2b_drain_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a multiply.
        issue(6'b011000, 32'hFFFF_FFFE, 32'd7, 5'd0, 1'b0);
        for (int i = 1; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid",  {31'd0, out_valid}, 32'd0);
        chk("mrst_result", result,             32'd0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        chk("mrst_ready", {31'd0, in_ready}, 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        chk("mrst_no_result", {31'd0, saw_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
